// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and the fetch-buffer entry type for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int PC_WIDTH_DEF = 12;

  localparam logic [3:0] OPC_BRANCH = 4'hC;
  localparam logic [3:0] OPC_JUMP   = 4'hD;
  localparam logic [3:0] OPC_NOP    = 4'hF;

  localparam logic [15:0] NOP_INSTR = {OPC_NOP, 12'h000};

  typedef struct packed {
    logic [PC_WIDTH_DEF-1:0] pc;
    logic [15:0]             instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order instruction buffer of depth 1 or 2; head is always entries[0].
// Simultaneous push and pop is legal at any fill level, including full.
module fetch_buffer
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  localparam logic [1:0] DEPTH_CNT = 2'(DEPTH);

  fetch_entry_t entries [DEPTH];
  logic [1:0]   wr_idx;

  // A pop in the same cycle frees the head slot, so the write lands one lower.
  assign wr_idx = count - {1'b0, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop) entries[0] <= entries[DEPTH-1];
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (wr_idx == 2'(i)) entries[i] <= push_data;
        end
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = entries[0];
  assign empty = (count == 2'd0);
  assign full  = (count == DEPTH_CNT);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: request/drop bookkeeping in front of a small prefetch buffer.
// Define FETCH_PREFETCH_BUF_EN for a 2-entry buffer (1 instr/cycle); default is 1 entry.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int                  PC_WIDTH = PC_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [15:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                if_valid,
  output logic [15:0]         if_instruction,
  output logic [PC_WIDTH-1:0] if_pc,
  input  logic                if_ready
);

`ifdef FETCH_PREFETCH_BUF_EN
  localparam int BUF_DEPTH = 2;
`else
  localparam int BUF_DEPTH = 1;
`endif
  localparam logic [2:0] SLOTS = 3'(BUF_DEPTH);

  // Handshakes: imem transfers when imem_req & imem_gnt, decode transfers when
  // if_valid & if_ready; a valid side never withdraws or changes its payload
  // before the transfer, the only exception being a redirect on the fetch side.

  logic [PC_WIDTH-1:0] fetch_pc;
  logic [PC_WIDTH-1:0] resp_pc;
  logic [1:0]          outstanding;
  logic [1:0]          outstanding_next;
  logic [1:0]          drop_cnt;
  logic [1:0]          buf_count;
  logic                buf_full;
  logic                buf_empty;
  logic [2:0]          occupancy;
  logic                pop;
  logic                grant;
  logic                resp;
  logic                discard;
  logic                push;
  fetch_entry_t        push_entry;
  fetch_entry_t        head_entry;

  assign pop = !buf_empty && if_ready;

  // Slots promised = buffered + in flight (including those to be dropped),
  // less the head leaving this cycle. Holding below SLOTS guarantees space.
  assign occupancy = {1'b0, buf_count} + {1'b0, outstanding} - {2'b00, pop};
  assign imem_req  = !rst && !(buf_full && !pop) && (occupancy < SLOTS);
  assign imem_addr = fetch_pc;

  assign grant   = imem_req && imem_gnt;
  assign resp    = imem_rvalid && (outstanding != 2'd0);
  assign discard = resp && (drop_cnt != 2'd0);
  assign push    = resp && !discard && !redirect_valid;

  assign outstanding_next = outstanding + {1'b0, grant} - {1'b0, resp};

  // Responses are in order and requests are sequential from the last redirect,
  // so the tag of the next kept response is simply a running PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc;
        resp_pc  <= redirect_pc;
        drop_cnt <= outstanding_next;
      end else begin
        if (grant)   fetch_pc <= fetch_pc + PC_WIDTH'(1);
        if (push)    resp_pc  <= resp_pc + PC_WIDTH'(1);
        if (discard) drop_cnt <= drop_cnt - 2'd1;
      end
    end
  end

  assign push_entry.pc          = resp_pc;
  assign push_entry.instruction = imem_rdata;

  fetch_buffer #(
    .DEPTH(BUF_DEPTH)
  ) u_fetch_buffer (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (buf_count),
    .full      (buf_full),
    .empty     (buf_empty)
  );

  assign if_valid       = !buf_empty;
  assign if_instruction = buf_empty ? NOP_INSTR : head_entry.instruction;
  assign if_pc          = buf_empty ? '0 : head_entry.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: memory responder, decode sink and an
// in-order program model (every non-squashed grant reaches decode exactly once).
module tb_instr_fetch_unit;

`ifdef FETCH_PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [15:0] NOP = 16'hF000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [11:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instruction;
  logic [11:0] if_pc;
  logic        if_ready;

  instr_fetch_unit #(
    .PC_WIDTH (12),
    .RESET_PC (12'h000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_ready       (if_ready)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model state ----------------
  typedef struct {
    logic [11:0] addr;
    int          due;
  } pend_t;

  pend_t       mem_q[$];
  logic [27:0] exp_q[$];
  logic [11:0] exp_req_pc;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int xfers = 0;
  int first_xfer_cyc = -1;
  logic [11:0] first_xfer_pc;
  logic [11:0] last_xfer_pc;

  int gnt_pct, rv_pct, rdy_pct, redir_pct;
  bit redir_now, redir_on_valid, stale_pending, first_req_pending;
  logic [11:0] redir_target;

  bit          prev_req, prev_gnt, prev_redir, prev_hold;
  logic [11:0] prev_addr, prev_if_pc;
  logic [15:0] prev_if_instr;

  function automatic logic [15:0] mem_word(input logic [11:0] a);
    return {a[3:0], a} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_knobs(input int g, input int r, input int d, input int x);
    gnt_pct = g; rv_pct = r; rdy_pct = d; redir_pct = x;
  endtask

  // ---------------- scoreboard: evaluated at negedge ----------------
  task automatic check_cycle();
    logic [27:0] e;
    if (first_req_pending) begin
      chk("first_req_after_reset", imem_req, 1);
      first_req_pending = 1'b0;
    end
    if (prev_req && !prev_gnt && !prev_redir) begin
      chk("req_hold", imem_req, 1);
      chk("addr_hold", imem_addr, prev_addr);
    end
    if (prev_redir) chk("valid_after_redirect", if_valid, 0);
    if (!if_valid) chk("empty_nop", if_instruction, NOP);
    if (prev_hold) begin
      chk("stall_valid_hold", if_valid, 1);
      chk("stall_pc_hold", if_pc, prev_if_pc);
      chk("stall_instr_hold", if_instruction, prev_if_instr);
    end
    if (if_valid && if_ready) begin
      chk("xfer_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("xfer_pc", if_pc, e[27:16]);
        chk("xfer_instr", if_instruction, e[15:0]);
      end
      if (first_xfer_cyc < 0) begin
        first_xfer_cyc = cyc;
        first_xfer_pc  = if_pc;
      end
      last_xfer_pc = if_pc;
      xfers++;
    end
    if (imem_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
    if (imem_req && imem_gnt) begin
      chk("req_addr", imem_addr, exp_req_pc);
      mem_q.push_back('{addr: imem_addr, due: cyc + 1});
      chk("outstanding_bound", mem_q.size() <= DEPTH, 1);
      if (!redirect_valid) exp_q.push_back({exp_req_pc, mem_word(exp_req_pc)});
      exp_req_pc = exp_req_pc + 12'd1;
    end
    if (redirect_valid) begin
      exp_q.delete();
      exp_req_pc = redirect_pc;
    end
    prev_req      = imem_req;
    prev_gnt      = imem_gnt;
    prev_addr     = imem_addr;
    prev_redir    = redirect_valid;
    prev_hold     = if_valid && !if_ready && !redirect_valid;
    prev_if_pc    = if_pc;
    prev_if_instr = if_instruction;
  endtask

  // ---------------- driver ----------------
  task automatic step();
    bit do_redir;
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b0;
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99) < rv_pct) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
    end
    if (stale_pending) begin
      imem_rvalid   = 1'b1;
      imem_rdata    = 16'hDEAD;
      stale_pending = 1'b0;
    end
    if_ready    = ($urandom_range(99) < rdy_pct);
    do_redir    = ($urandom_range(99) < redir_pct);
    redirect_pc = 12'($urandom);
    if (redir_now || (redir_on_valid && if_valid && if_ready)) begin
      do_redir       = 1'b1;
      redirect_pc    = redir_target;
      redir_now      = 1'b0;
      redir_on_valid = 1'b0;
    end
    redirect_valid = do_redir;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic do_reset(input bit stale);
    @(posedge clk);
    #1;
    cyc++;
    rst = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; redirect_valid = 1'b0; if_ready = 1'b0;
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 12'h000);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instruction, NOP);
    chk("rst_pc", if_pc, 12'h000);
    @(posedge clk);
    #1;
    cyc++;
    @(negedge clk);
    chk("rst_hold_req", imem_req, 0);
    mem_q.delete();
    exp_q.delete();
    exp_req_pc        = 12'h000;
    prev_req          = 1'b0;
    prev_redir        = 1'b0;
    prev_hold         = 1'b0;
    first_xfer_cyc    = -1;
    stale_pending     = stale;
    first_req_pending = 1'b1;
  endtask

  task automatic wait_xfers(input int n, input int budget);
    int target;
    int k;
    target = xfers + n;
    k = 0;
    while (xfers < target && k < budget) begin step(); k++; end
    chk("xfer_progress", xfers, target);
  endtask

  task automatic wait_outstanding(input int n, input int budget);
    int k;
    k = 0;
    while (mem_q.size() < n && k < budget) begin step(); k++; end
    chk("outstanding_reached", mem_q.size() >= n, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    int rel;
    int x0;
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    redir_now = 1'b0; redir_on_valid = 1'b0; redir_target = '0;
    stale_pending = 1'b0; first_req_pending = 1'b0;
    exp_req_pc = '0; first_xfer_pc = '0; last_xfer_pc = '0;
    prev_gnt = 1'b0; prev_addr = '0; prev_if_pc = '0; prev_if_instr = '0;
    set_knobs(0, 0, 0, 0);

    // Streaming after reset: latency and throughput.
    do_reset(1'b0);
    set_knobs(100, 100, 100, 0);
    rel = cyc + 1;
    x0  = xfers;
    repeat (10) step();
    chk("first_valid_cycle", first_xfer_cyc, rel + 2);
    chk("first_pc", first_xfer_pc, 12'h000);
    chk("stream_count", xfers - x0, (DEPTH == 2) ? 8 : 4);

    // Decode stall for 5 cycles after the first instruction.
    do_reset(1'b0);
    set_knobs(100, 100, 0, 0);
    k = 0;
    while (!if_valid && k < 10) begin step(); k++; end
    chk("stall_first_valid", if_valid, 1);
    repeat (5) step();
    chk("stall_req_low", imem_req, 0);
    chk("stall_pc", if_pc, 12'h000);
    set_knobs(100, 100, 100, 0);
    wait_xfers(6, 40);

    // Redirect with the maximum number of responses in flight.
    set_knobs(100, 0, 100, 0);
    wait_outstanding(DEPTH, 20);
    chk("outstanding_at_redirect", mem_q.size(), DEPTH);
    redir_target = 12'h040;
    redir_now    = 1'b1;
    step();
    set_knobs(100, 100, 100, 0);
    wait_xfers(1, 40);
    chk("redirect_first_pc", last_xfer_pc, 12'h040);
    wait_xfers(1, 40);
    chk("redirect_second_pc", last_xfer_pc, 12'h041);

    // PC wrap.
    redir_target = 12'hFFE;
    redir_now    = 1'b1;
    step();
    wait_xfers(3, 40);
    chk("wrap_pc", last_xfer_pc, 12'h000);

    // Redirect in the same cycle as a decode transfer.
    redir_target   = 12'h123;
    redir_on_valid = 1'b1;
    k = 0;
    while (redir_on_valid && k < 20) begin step(); k++; end
    chk("xfer_redirect_issued", redir_on_valid, 0);
    wait_xfers(1, 40);
    chk("xfer_redirect_pc", last_xfer_pc, 12'h123);

    // Reset with a request in flight and a late response after release.
    set_knobs(100, 0, 100, 0);
    wait_outstanding(1, 20);
    do_reset(1'b1);
    set_knobs(100, 100, 100, 0);
    wait_xfers(3, 40);
    chk("post_reset_first_pc", first_xfer_pc, 12'h000);

    // Random traffic with random redirects.
    set_knobs(70, 60, 70, 3);
    x0 = xfers;
    repeat (3000) step();
    chk("random_progress", (xfers - x0) > 100, 1);
    set_knobs(0, 100, 100, 0);
    repeat (20) step();
    chk("drain_decode", exp_q.size(), 0);
    chk("drain_memory", mem_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameters SHALL be:
- PC_WIDTH, 12, word-address width.
- RESET_PC, 12'h000, first fetch address.
REQ-002 Ports SHALL be:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  PC_WIDTH  fetch word address.
- imem_gnt  in  1  request accepted this cycle when imem_req=1.
- imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
- imem_rdata  in  16  instruction word.
- redirect_valid  in  1  taken branch or jump from execute.
- redirect_pc  in  PC_WIDTH  new fetch address.
- if_valid  out  1  instruction available to decode.
- if_instruction  out  16  instruction to decode.
- if_pc  out  PC_WIDTH  address of if_instruction.
- if_ready  in  1  decode accepts; transfer when if_valid & if_ready.
REQ-003 There SHALL be one clock; rst SHALL be asynchronous and active-high.

Function
REQ-004 The fetch PC SHALL advance by 1 per granted request and wrap from 12'hFFF to 12'h000.
REQ-005 imem_req SHALL assert only when a free buffer slot is guaranteed: free slots minus outstanding requests > 0.
REQ-006 Once asserted, imem_req and imem_addr SHALL hold stable until imem_gnt, except on redirect.
REQ-007 Each response SHALL be written into the buffer tagged with its request PC, unless marked for discard.
REQ-008 On redirect_valid, in the same cycle: the buffer SHALL flush; if_valid SHALL be 0 from the next cycle; all outstanding responses SHALL be marked for discard via a drop counter; fetch PC SHALL load redirect_pc; and the next imem_req SHALL use redirect_pc.
REQ-009 A response arriving with drop counter > 0 SHALL decrement the counter and be discarded.
REQ-010 Redirect and decode acceptance in the same cycle: the transfer SHALL complete, then the flush SHALL apply.
REQ-011 Redirect and grant in the same cycle: the granted request SHALL count as outstanding and be discarded.
REQ-012 Buffer full and if_ready=0: if_valid, if_instruction and if_pc SHALL hold stable, with no new request.
REQ-013 Buffer empty: if_valid SHALL be 0; if_instruction SHALL read 16'hF000 (NOP).
REQ-014 Write and read of the buffer in the same cycle SHALL be legal when full.
REQ-015 Minimum latency SHALL be: grant at cycle N, rvalid at N+1, if_valid at N+2 (registered output).

Reset
REQ-016 While rst=1, outputs SHALL be: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instruction=16'hF000, if_pc=0. The buffer and drop counter SHALL be empty/0.
REQ-017 The first imem_req SHALL assert the cycle after rst deasserts.
REQ-018 Reset mid-transaction SHALL abandon all outstanding requests. Responses received after reset and before the first post-reset grant SHALL be ignored.

Configuration
REQ-019 Macro FETCH_PREFETCH_BUF_EN defined: 2-entry FIFO buffer, up to 2 outstanding requests, sustained 1 instruction/cycle.
REQ-020 Macro absent: 1-entry buffer, at most 1 outstanding request, throughput 1 instruction per 2 cycles minimum. The interface SHALL be unchanged.

Structure
REQ-021 The shared package SHALL hold: PC_WIDTH default, the NOP encoding 16'hF000, the opcode constants, and the fetch-buffer entry typedef {pc, instruction}.
REQ-022 The buffer SHALL be sub-module fetch_buffer (depth parameter 1 or 2, full/empty flags). The request/drop logic SHALL stay in instr_fetch_unit.

Verification
REQ-023 Reset release, memory always granting, rvalid 1 cycle later, if_ready=1 -> if_pc sequence 0,1,2,3; with the macro, one per cycle from cycle 3.
REQ-024 if_ready=0 for 5 cycles after the first instruction -> if_pc=0 held stable, imem_req drops once buffer+outstanding are full, no instruction lost.
REQ-025 redirect_valid with redirect_pc=12'h040 while 2 responses are outstanding -> both discarded, next if_pc=12'h040, then 12'h041.
REQ-026 Fetch from 12'hFFE continuously -> if_pc 12'hFFE, 12'hFFF, 12'h000.
REQ-027 rst asserted while a request is outstanding, with the late rvalid arriving after release -> stale data never appears, first if_pc=RESET_PC.
REQ-028 Redirect in the same cycle as an if_valid&if_ready transfer -> the transferred instruction is counted once, the following if_pc equals redirect_pc.
